// File: rtl/tqvp_arb_pkg.sv
// Shared types and default sizing for the peripheral register-port arbiter.
// Also used by the OFDM sequencer, which reuses the round-robin picker.
package tqvp_arb_pkg;

  localparam int DEF_N_REQ  = 2;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tqvp_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Returns a one-hot grant, the winner's index and whether any request was set.
module tqvp_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] rotLow;
  int               offset;
  int               winner;

  // Rotate so the pointer position lands at bit 0; the lowest set bit is the winner.
  assign rotLow = N_REQ'({req_i, req_i} >> ptr_i);

  always_comb begin
    offset  = 0;
    valid_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotLow[k]) begin
        offset  = k;
        valid_o = 1'b1;
      end
    end
    winner = offset + int'(ptr_i);
    if (winner >= N_REQ) begin
      winner = winner - N_REQ;
    end
    idx_o   = IDX_W'(winner);
    grant_o = valid_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/tqvp_reg_arbiter.sv
// Round-robin arbiter sharing one peripheral register port between N_REQ requesters.
// Define ARB_FIXED_PRIO_EN to pin the priority pointer at 0 (fixed lowest-index priority).
module tqvp_reg_arbiter
  import tqvp_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         data_in,
  output logic                      data_write,
  input  logic [DATA_W-1:0]         data_out,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptrEff;
  logic [N_REQ-1:0]  pickGrant;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickValid;

  tqvp_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptrEff),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign ptrEff = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // The pointer moves past the owner only once its transaction has completed.
  assign ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == RESP) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptrEff = ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (pickGrant[i]) begin
              addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
          we_d    = |(req_we & pickGrant);
          owner_d = pickIdx;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = data_out;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
    end
  end

  // Outputs decode straight from state so a reset clears them without waiting for a clock.
  assign ack        = (state_q == RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign busy       = (state_q != IDLE);
  assign data_write = (state_q == ACCESS) && we_q;
  assign address    = addr_q;
  assign data_in    = wdata_q;
  assign rdata      = rdata_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Directed bench for tqvp_reg_arbiter with a scoreboard of expected transactions.
// Expected ack order follows ARB_FIXED_PRIO_EN when that macro is defined.
module tb_tqvp_reg_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req;
  logic [N-1:0]           req_we;
  logic [N*AW-1:0]        req_addr;
  logic [N*DW-1:0]        req_wdata;
  logic [N-1:0]           ack;
  logic [DW-1:0]          rdata;
  logic [AW-1:0]          address;
  logic [DW-1:0]          data_in;
  logic                   data_write;
  logic [DW-1:0]          data_out;
  logic                   busy;
  logic [$clog2(N)-1:0]   owner;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCnt    = 0;
  int dwCount     = 0;

  logic [DW-1:0] mem    [16];
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] lastRdata;

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t sb[$];

  tqvp_reg_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .rdata      (rdata),
    .address    (address),
    .data_in    (data_in),
    .data_write (data_write),
    .data_out   (data_out),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  // Peripheral model: combinational read, write on the clock edge.
  assign data_out = mem[address];

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (data_write) begin
      dwCount      <= dwCount + 1;
      mem[address] <= data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ackOneHot0", {31'b0, $onehot0(ack)}, 32'd1);
      check("dwOutsideAccess", {31'b0, data_write && !(busy && ack == '0)}, 32'd0);
    end
  end

  task automatic expectTxn(input int idx, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    txn_t t;
    t.idx   = idx;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = we ? 8'h00 : shadow[addr];
    if (we) begin
      shadow[addr] = wdata;
    end
    sb.push_back(t);
  endtask

  task automatic applyStimulus(input int idx, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input bit push);
    req_we[idx]             = we;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wdata;
    req[idx]                = 1'b1;
    if (push) begin
      expectTxn(idx, we, addr, wdata);
    end
  endtask

  task automatic checkOutput(input string tag, input bit dropReq, output int waited,
                             output int ackCycle);
    txn_t          t;
    logic [DW-1:0] expR;
    waited   = 0;
    ackCycle = 0;
    while (waited < 12) begin
      @(negedge clk);
      waited++;
      if (ack != '0) break;
    end
    if (ack == '0 || sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL %s: ack=0x%0h after %0d cycles, queued=%0d, required one expected ack",
             tag, ack, waited, sb.size());
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      t    = sb.pop_front();
      expR = t.we ? lastRdata : t.rdata;
      check($sformatf("%s.ack", tag), 32'(ack), 32'(1) << t.idx);
      check($sformatf("%s.owner", tag), 32'(owner), t.idx);
      check($sformatf("%s.rdata", tag), 32'(rdata), 32'(expR));
      lastRdata = expR;
      ackCycle  = cycleCnt;
      if (dropReq) begin
        req[t.idx] = 1'b0;
      end
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    lastRdata = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waited, c0, c1, dw0, ackSeen, idxK;
    bit  fixedPrio;
`ifdef ARB_FIXED_PRIO_EN
    fixedPrio = 1'b1;
`else
    fixedPrio = 1'b0;
`endif
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rst_n     = 1'b0;
    lastRdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 8'(i * 17);
      shadow[i] = 8'(i * 17);
    end
    mem[7]    = 8'h5A;
    shadow[7] = 8'h5A;

    @(negedge clk);
    check("rst.ack", 32'(ack), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.dataWrite", 32'(data_write), 0);
    check("rst.address", 32'(address), 0);
    check("rst.dataIn", 32'(data_in), 0);
    check("rst.rdata", 32'(rdata), 0);
    check("rst.owner", 32'(owner), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write from requester 0
    dw0 = dwCount;
    applyStimulus(0, 1'b1, 4'd3, 8'hA5, 1'b1);
    @(negedge clk);
    check("write.busy", 32'(busy), 1);
    check("write.ackEarly", 32'(ack), 0);
    check("write.address", 32'(address), 3);
    check("write.dataIn", 32'(data_in), 32'h A5);
    check("write.dataWrite", 32'(data_write), 1);
    checkOutput("write", 1'b1, waited, c0);
    check("write.latency", waited, 1);
    check("write.dwPulses", dwCount - dw0, 1);
    check("write.mem", 32'(mem[3]), 32'h A5);

    // Single read from requester 1
    @(negedge clk);
    dw0 = dwCount;
    applyStimulus(1, 1'b0, 4'd7, 8'h00, 1'b1);
    checkOutput("read", 1'b1, waited, c0);
    check("read.latency", waited, 2);
    check("read.noWrite", dwCount - dw0, 0);
    repeat (2) @(negedge clk);
    check("read.rdataHold", 32'(rdata), 32'h5A);

    // Contention straight after reset
    resetDut();
    applyStimulus(0, 1'b1, 4'd5, 8'hC3, 1'b1);
    applyStimulus(1, 1'b0, 4'd6, 8'h00, 1'b1);
    checkOutput("cont0", 1'b1, waited, c0);
    checkOutput("cont1", 1'b1, waited, c1);
    check("cont.spacing", c1 - c0, 3);

    // Continuous contention: both requesters hold req for six transactions
    @(negedge clk);
    applyStimulus(0, 1'b0, 4'd1, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 4'd2, 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      idxK = fixedPrio ? 0 : (k % 2);
      expectTxn(idxK, 1'b0, (idxK == 0) ? 4'd1 : 4'd2, 8'h00);
    end
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("rr%0d", k), 1'b0, waited, c0);
    end
    req = '0;

    // Abandoned request: req dropped during ACCESS
    repeat (2) @(negedge clk);
    applyStimulus(0, 1'b1, 4'd4, 8'h3C, 1'b1);
    @(negedge clk);
    req[0] = 1'b0;
    checkOutput("abandon", 1'b0, waited, c0);
    @(negedge clk);
    check("abandon.idle1", 32'(busy), 0);
    @(negedge clk);
    check("abandon.idle2", 32'({busy, ack}), 0);
    check("abandon.mem", 32'(mem[4]), 32'h3C);

    // Reset in the middle of a write
    applyStimulus(0, 1'b1, 4'd9, 8'h77, 1'b0);
    @(negedge clk);
    check("midRst.preDw", 32'(data_write), 1);
    check("midRst.preAddr", 32'(address), 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("midRst.dataWrite", 32'(data_write), 0);
    check("midRst.ack", 32'(ack), 0);
    check("midRst.busy", 32'(busy), 0);
    check("midRst.address", 32'(address), 0);
    req = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    lastRdata = '0;
    ackSeen   = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0) ackSeen++;
    end
    check("midRst.lostNoAck", ackSeen, 0);
    check("midRst.memUntouched", 32'(mem[9]), 32'(shadow[9]));

    applyStimulus(0, 1'b0, 4'd1, 8'h00, 1'b1);
    applyStimulus(1, 1'b0, 4'd2, 8'h00, 1'b1);
    checkOutput("postRst0", 1'b1, waited, c0);
    checkOutput("postRst1", 1'b1, waited, c1);
    check("scoreboardEmpty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/tqvp_reg_arbiter.md
Name: tqvp_reg_arbiter

Overview:
Shares the single peripheral register port (4-bit address, 8-bit write data, write strobe, 8-bit combinational read data) between N requesters, for example the SPI register bridge and an on-chip OFDM configuration sequencer. Arbitration is round-robin. Each requester gets one complete read or write transaction per grant, terminated by an ack pulse. The block sits between the requesters and the peripheral under test in the test harness.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 4, register address width
DATA_W, 8, register data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level; held until ack
req_we  in  N_REQ  1=write, 0=read; valid while req
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
ack  out  N_REQ  one-cycle completion pulse to the owning requester
rdata  out  DATA_W  read data; valid in the ack cycle, held until next read completes
address  out  ADDR_W  to peripheral
data_in  out  DATA_W  write data to peripheral
data_write  out  1  peripheral write strobe
data_out  in  DATA_W  peripheral read data (combinational from address)
busy  out  1  high in ACCESS and RESP
owner  out  $clog2(N_REQ)  index of current/last granted requester

Behaviour:
- Reset (async, rst_n=0): state IDLE; address, data_in, rdata, owner = 0; data_write, ack, busy = 0; RR pointer = 0 (requester 0 highest priority).
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: req is sampled only in this state. If any req bit is set, pick the first set bit starting at the RR pointer and wrapping modulo N_REQ. Register the winner's we, addr and wdata into address, data_in and a we flop; set owner; go to ACCESS. With no req, stay in IDLE; address and data_in hold their last values.
- ACCESS (1 cycle): data_write = latched we. Latch rdata <= data_out only if the transaction is a read; a write leaves rdata unchanged. Go to RESP.
- RESP (1 cycle): ack[owner] = 1; RR pointer <= (owner+1) mod N_REQ; go to IDLE.
- Latency: ack arrives 2 cycles after the IDLE cycle in which req is sampled. Peak throughput: 1 transaction per 3 cycles.
- A requester must drop req in the cycle after ack. If req is still high in the following IDLE cycle, it is a new request.
- Once granted, a transaction is committed. Dropping req during ACCESS or RESP does not abort it; ack still pulses.
- Simultaneous requests: only the winner advances. Losers keep req and are served in RR order. With all requesters continuously active, grants rotate 0,1,...,N_REQ-1,0.
- data_write is never high outside ACCESS. At most one ack bit is set per cycle.
- Reset mid-transaction: all state is cleared immediately. No ack or data_write is emitted, and the pending transaction is lost.
- Ignore changes to req_addr, req_wdata and req_we after the IDLE sample.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: the RR pointer is tied to 0, so the lowest-index active requester always wins. Requester 0 can starve the others.
- Undefined: round-robin as above.
All other timing is identical in both builds.

Decomposition:
- Package tqvp_arb_pkg: FSM state enum (IDLE, ACCESS, RESP), default width constants.
- One sub-module, tqvp_rr_pick: combinational priority picker taking req and pointer, returning a one-hot grant and its index. It is reusable by the OFDM sequencer.

Test Plan:
- Write: req[0]=1, we=1, addr=3, wdata=0xA5 -> in ACCESS, address=3, data_in=0xA5, data_write=1 for exactly 1 cycle; ack[0] 2 cycles after sample; rdata unchanged.
- Read: peripheral model returns 0x5A at addr 7; req[1]=1, we=0, addr=7 -> data_write stays 0; ack[1] pulse with rdata=0x5A; rdata holds 0x5A afterwards.
- Contention after reset: req=2'b11 in the same cycle -> requester 0 served first, then requester 1; one transaction completes every 3 cycles; ack never has both bits set.
- Continuous contention: both requesters re-raise req for 6 transactions -> ack order 0,1,0,1,0,1. With ARB_FIXED_PRIO_EN -> 0,0,0,... and requester 1 is never acked.
- Abandoned request: req[0] dropped during ACCESS -> write still performed, ack[0] still pulses, next IDLE grants nothing.
- Reset mid-transaction: assert rst_n=0 during ACCESS -> data_write, ack, busy, address go to 0 asynchronously; after release, no ack for the lost transaction and the RR pointer is 0.
